// File: rtl/ripple_counter_sequencer_pkg.sv
// Shared definitions for the ripple counter sequencer.
//   - Command opcodes carried on the command interface.
//   - Counter direction encoding driven on cnt_count.
//   - Sequencer FSM state encoding, also exposed on the debug state port.
//   - Width of the settle timer (settle lengths 1..15).
package ripple_counter_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_GOTO = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int SETTLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TICK   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/ripple_counter_sequencer_if.sv
// Command channel into the ripple counter sequencer.
//   valid : command present (driven by the requester)
//   ready : sequencer can take a command (driven by the sequencer)
//   op    : opcode, see OP_* in ripple_counter_pkg
//   arg   : LOAD/GOTO target value, UP/DOWN step count
// Handshake: a command transfers on a rising clk edge where valid && ready.
// The requester holds op/arg stable while valid is high and ready is low;
// ready does not depend on valid.
interface ripple_counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             valid;
    logic             ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] arg;

    modport master (output valid, output op, output arg, input ready);
    modport slave  (input valid, input op, input arg, output ready);
endinterface

// File: rtl/ripple_counter_sequencer_settle_timer.sv
// settle_timer: counts the wait after each counter tick so the ripple
// output has time to propagate before it is sampled.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the timer at SETTLE_CYCLES
//   expire     : high in the last of the SETTLE_CYCLES cycles after load
module settle_timer
    import ripple_counter_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);
    logic [SETTLE_W-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= SETTLE_W'(SETTLE_CYCLES);
        end else if (remaining != '0) begin
            remaining <= remaining - SETTLE_W'(1);
        end
    end

    // Last waiting cycle, so the FSM leaves SETTLE after exactly SETTLE_CYCLES.
    assign expire = (remaining == SETTLE_W'(1));
endmodule

// File: rtl/ripple_counter_sequencer.sv
// ripple_counter_sequencer: command-driven controller for a loadable
// up/down ripple counter. Each tick is followed by a settle wait, then the
// counter output is checked against a shadow copy of the expected value.
//   clk, rst_n : clock, asynchronous active-low reset
//   cmd        : command channel (slave side), LOAD / UP n / DOWN n / GOTO
//   cnt_in     : parallel-load value to the counter
//   cnt_load   : counter load select
//   cnt_count  : counter direction, DIR_UP=0 / DIR_DOWN=1
//   cnt_tick   : one-cycle counter clock enable
//   cnt_out    : counter value (asynchronous ripple output)
//   busy       : command in progress, accept through DONE
//   done       : one-cycle completion pulse
//   error      : with done: counter disagreed with shadow; held until next accept
//   state      : current FSM state (debug)
module ripple_counter_sequencer
    import ripple_counter_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ripple_counter_sequencer_if.slave cmd,
    output logic [WIDTH-1:0]          cnt_in,
    output logic                      cnt_load,
    output logic                      cnt_count,
    output logic                      cnt_tick,
    input  logic [WIDTH-1:0]          cnt_out,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output state_t                    state
);
    state_t           state_next;
    logic             accept;
    logic             settle_expire;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] acc_steps;
    logic             acc_dir;
    logic             mismatch;
    logic             last_step;

    assign cmd.ready = (state == ST_IDLE);
    assign accept    = cmd.valid && cmd.ready;
    assign mismatch  = (cnt_out != expected);
    assign last_step = (remaining == WIDTH'(1)) || (op_q == OP_LOAD);

    // Step count and direction for the incoming command. LOAD is a single
    // tick; GOTO walks straight toward the target without wrapping.
    always_comb begin
        acc_steps = cmd.arg;
        acc_dir   = cnt_count;
        case (cmd.op)
            OP_LOAD: acc_steps = WIDTH'(1);
            OP_UP:   acc_dir   = DIR_UP;
            OP_DOWN: acc_dir   = DIR_DOWN;
            default: begin
                if (cmd.arg > shadow) begin
                    acc_steps = cmd.arg - shadow;
                    acc_dir   = DIR_UP;
                end else if (cmd.arg < shadow) begin
                    acc_steps = shadow - cmd.arg;
                    acc_dir   = DIR_DOWN;
                end else begin
                    acc_steps = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        cnt_tick   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_next = (acc_steps == '0) ? ST_DONE : ST_TICK;
                end
            end
            ST_TICK: begin
                cnt_tick   = 1'b1;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_expire) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = (mismatch || last_step) ? ST_DONE : ST_TICK;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_LOAD;
            shadow    <= '0;
            expected  <= '0;
            remaining <= '0;
            cnt_in    <= '0;
            cnt_load  <= 1'b0;
            cnt_count <= DIR_UP;
            error     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= cmd.op;
                        remaining <= acc_steps;
                        cnt_count <= acc_dir;
                        error     <= 1'b0;
                        if (cmd.op == OP_LOAD) begin
                            cnt_in   <= cmd.arg;
                            cnt_load <= 1'b1;
                        end
                    end
                end
                ST_TICK: begin
                    if (op_q == OP_LOAD) begin
                        expected <= cnt_in;
                    end else if (cnt_count == DIR_DOWN) begin
                        expected <= shadow - WIDTH'(1);
                    end else begin
                        expected <= shadow + WIDTH'(1);
                    end
                end
                ST_CHECK: begin
                    cnt_load  <= 1'b0;
                    remaining <= remaining - WIDTH'(1);
                    if (mismatch) begin
                        error  <= 1'b1;
                        shadow <= cnt_out;
                    end else begin
                        shadow <= expected;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state == ST_TICK),
        .expire (settle_expire)
    );
endmodule

// File: tb/tb_ripple_counter_sequencer.sv
module tb_ripple_counter_sequencer;
    import ripple_counter_pkg::*;

    localparam int W       = 4;
    localparam int S       = 2;
    localparam int MOD     = 1 << W;
    localparam int STUCK_V = 5;

    typedef struct packed {
        logic tick;
        logic load;
        logic done;
        logic err;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ripple_counter_sequencer_if #(.WIDTH(W)) cmd_if ();

    logic [W-1:0] cnt_in;
    logic [W-1:0] cnt_out;
    logic [W-1:0] cnt_q;
    logic         cnt_load;
    logic         cnt_count;
    logic         cnt_tick;
    logic         busy;
    logic         done;
    logic         error;
    state_t       state;
    logic         stuck = 1'b0;

    ripple_counter_sequencer #(
        .WIDTH(W),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .cnt_in    (cnt_in),
        .cnt_load  (cnt_load),
        .cnt_count (cnt_count),
        .cnt_tick  (cnt_tick),
        .cnt_out   (cnt_out),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .state     (state)
    );

    // Counter under control: loads or steps on each tick; can be forced stuck.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (cnt_tick) cnt_q <= cnt_load ? cnt_in : (cnt_count ? cnt_q - 1'b1 : cnt_q + 1'b1);
    end
    assign cnt_out = stuck ? W'(STUCK_V) : cnt_q;

    // ---------------- scoreboard / model ----------------
    exp_t         exp_q[$];
    int           m_shadow = 0;
    int           m_cnt    = 0;
    logic         m_dir    = 1'b0;
    logic         m_err    = 1'b0;
    logic [W-1:0] m_in     = '0;
    int           n_pass   = 0;
    int           n_chk    = 0;
    logic [W-1:0] seen_q[$];
    int           r_lat;
    int           r_ticks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    endtask

    // Builds the cycle-by-cycle expectation of one accepted command.
    task automatic build_trace(input logic [1:0] op, input int arg);
        int   steps;
        int   exp_v;
        int   act_v;
        logic ld;
        ld    = (op == OP_LOAD);
        steps = 0;
        m_err = 1'b0;
        case (op)
            OP_LOAD: begin steps = 1; m_in = W'(arg); end
            OP_UP:   begin steps = arg; m_dir = 1'b0; end
            OP_DOWN: begin steps = arg; m_dir = 1'b1; end
            default: begin
                if (arg > m_shadow) begin steps = arg - m_shadow; m_dir = 1'b0; end
                else if (arg < m_shadow) begin steps = m_shadow - arg; m_dir = 1'b1; end
            end
        endcase
        for (int k = 0; k < steps; k++) begin
            exp_q.push_back('{1'b1, ld, 1'b0, 1'b0});
            repeat (S + 1) exp_q.push_back('{1'b0, ld, 1'b0, 1'b0});
            exp_v = ld ? arg : (m_shadow + (m_dir ? MOD - 1 : 1)) % MOD;
            m_cnt = ld ? arg : (m_cnt + (m_dir ? MOD - 1 : 1)) % MOD;
            act_v = stuck ? STUCK_V : m_cnt;
            if (act_v != exp_v) begin
                m_err    = 1'b1;
                m_shadow = act_v;
                break;
            end
            m_shadow = exp_v;
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b1, m_err});
    endtask

    // Compare process: every cycle, all control outputs against the model.
    exp_t       cmp_e;
    logic [6:0] cmp_act;
    logic [6:0] cmp_want;
    always @(negedge clk) begin
        cmp_act = {cmd_if.ready, busy, cnt_tick, done, cnt_load, error, cnt_count};
        if (!rst_n) begin
            check("reset_outputs", 32'(cmp_act), 32'(7'b1000000));
            check("reset_cnt_in", 32'(cnt_in), 32'd0);
        end else if (exp_q.size() > 0) begin
            cmp_e    = exp_q.pop_front();
            cmp_want = {1'b0, 1'b1, cmp_e.tick, cmp_e.done, cmp_e.load, cmp_e.err, m_dir};
            check("busy_outputs", 32'(cmp_act), 32'(cmp_want));
            if (cmp_e.load) check("cnt_in", 32'(cnt_in), 32'(m_in));
        end else begin
            cmp_want = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_err, m_dir};
            check("idle_outputs", 32'(cmp_act), 32'(cmp_want));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_cmd(input logic [1:0] op, input int arg);
        int guard;
        guard = 0;
        @(negedge clk);
        cmd_if.valid = 1'b1;
        cmd_if.op    = op;
        cmd_if.arg   = W'(arg);
        while (!cmd_if.ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", 32'(cmd_if.ready), 32'd1);
        @(posedge clk);
        build_trace(op, arg);
    endtask

    task automatic wait_done();
        r_lat   = 0;
        r_ticks = 0;
        seen_q.delete();
        do begin
            @(negedge clk);
            if (r_lat == 0) cmd_if.valid = 1'b0;
            r_lat++;
            if (cnt_tick) r_ticks++;
            if (state == ST_CHECK) seen_q.push_back(cnt_out);
        end while (!done && r_lat < 400);
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run(input logic [1:0] op, input int arg);
        start_cmd(op, arg);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] rop;
        int         rarg;
        cmd_if.valid = 1'b0;
        cmd_if.op    = OP_LOAD;
        cmd_if.arg   = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(cmd_if.ready), 32'd1);
        check("rst_error", 32'(error), 32'd0);

        // LOAD 9
        run(OP_LOAD, 9);
        check("load9_latency", r_lat, 5);
        check("load9_ticks", r_ticks, 1);
        check("load9_error", 32'(error), 32'd0);
        check("load9_cnt", 32'(cnt_out), 32'd9);
        check("load9_model_shadow", m_shadow, 9);

        // LOAD 14, UP 3 through the wrap
        run(OP_LOAD, 14);
        run(OP_UP, 3);
        check("up3_ticks", r_ticks, 3);
        check("up3_latency", r_lat, 13);
        check("up3_seen0", 32'(seen_q[0]), 32'd15);
        check("up3_seen1", 32'(seen_q[1]), 32'd0);
        check("up3_seen2", 32'(seen_q[2]), 32'd1);
        check("up3_error", 32'(error), 32'd0);

        // LOAD 1, DOWN 2, then GOTO 15 with nothing to do
        run(OP_LOAD, 1);
        run(OP_DOWN, 2);
        check("down2_seen0", 32'(seen_q[0]), 32'd0);
        check("down2_seen1", 32'(seen_q[1]), 32'd15);
        check("down2_dir", 32'(cnt_count), 32'd1);
        run(OP_GOTO, 15);
        check("goto_same_latency", r_lat, 1);
        check("goto_same_ticks", r_ticks, 0);

        // GOTO 3 from 12, then UP 0
        run(OP_LOAD, 12);
        run(OP_GOTO, 3);
        check("goto3_ticks", r_ticks, 9);
        check("goto3_cnt", 32'(cnt_out), 32'd3);
        run(OP_UP, 0);
        check("up0_latency", r_lat, 1);
        check("up0_ticks", r_ticks, 0);

        // UP 15 from 3 ends at 2
        run(OP_LOAD, 3);
        run(OP_UP, 15);
        check("up15_ticks", r_ticks, 15);
        check("up15_cnt", 32'(cnt_out), 32'd2);

        // Counter stuck at 5 during UP 4
        run(OP_LOAD, 5);
        stuck = 1'b1;
        run(OP_UP, 4);
        check("stuck_error", 32'(error), 32'd1);
        check("stuck_ticks", r_ticks, 1);
        stuck = 1'b0;
        run(OP_LOAD, 0);
        check("stuck_cleared", 32'(error), 32'd0);

        // Command held while busy waits for IDLE
        start_cmd(OP_LOAD, 7);
        start_cmd(OP_UP, 2);
        wait_done();
        check("held_ticks", r_ticks, 2);
        check("held_cnt", 32'(cnt_out), 32'd9);

        // Reset during SETTLE of DOWN 6
        run(OP_LOAD, 10);
        start_cmd(OP_DOWN, 6);
        @(negedge clk);
        @(negedge clk);
        check("abort_in_settle", 32'(state), 32'(ST_SETTLE));
        #2 rst_n = 1'b0;
        exp_q.delete();
        m_shadow     = 0;
        m_cnt        = 0;
        m_dir        = 1'b0;
        m_err        = 1'b0;
        m_in         = '0;
        cmd_if.valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(cmd_if.ready), 32'd1);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run(OP_LOAD, 4);
        check("after_abort_cnt", 32'(cnt_out), 32'd4);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rop  = 2'($urandom_range(0, 3));
            rarg = $urandom_range(0, MOD - 1);
            run(rop, rarg);
            check("rand_cnt", 32'(cnt_out), 32'(m_shadow));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
